// File: rtl/c5_reset_ctrl.sv
// SoC reset sequencer: synchronises PLL lock and the board button, debounces the button,
// stretches reset release and records the last reset cause. Optional watchdog under `RST_WDT_EN.
`timescale 1ns/1ps
module c5_reset_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int WDT_CYCLES      = 1024
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_rst_btn,
    input  logic       I_pll_locked,
    input  logic       I_wdt_kick,
    output logic       O_rst_n,
    output logic       O_in_reset,
    output logic [1:0] O_rst_cause
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;
    typedef enum logic [1:0] {
        CAUSE_POR  = 2'd0,
        CAUSE_BTN  = 2'd1,
        CAUSE_LOCK = 2'd2,
        CAUSE_WDT  = 2'd3
    } cause_t;

    logic              btn_meta, btn_s, lock_meta, lock_s;
    logic              btn_db;
    logic [DEB_W-1:0]  deb_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              wdt_expire;
    state_t            state_q, state_d;
    cause_t            cause_q, cause_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            btn_meta  <= 1'b0;
            btn_s     <= 1'b0;
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            btn_meta  <= I_rst_btn;
            btn_s     <= btn_meta;
            lock_meta <= I_pll_locked;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            btn_db  <= 1'b0;
            deb_cnt <= '0;
        end else if (btn_s != btn_db) begin
            if (deb_cnt == DEB_LAST) begin
                btn_db  <= btn_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

`ifdef RST_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    logic [WDT_W-1:0] wdt_cnt;

    // Counter only runs while staying in RUN, so it is already zero on RUN entry.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wdt_cnt <= '0;
        end else if (state_q != RUN || state_d != RUN || I_wdt_kick) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end

    assign wdt_expire = (state_q == RUN) && (wdt_cnt == WDT_LAST) && !I_wdt_kick;
`else
    logic unused_wdt;
    assign unused_wdt = I_wdt_kick & (WDT_CYCLES >= 2);
    assign wdt_expire = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s && !btn_db) state_d = HOLD;
            end
            HOLD: begin
                if (!lock_s || btn_db)         state_d = WAIT_LOCK;
                else if (hold_cnt == HOLD_LAST) state_d = RUN;
            end
            RUN: begin
                if (btn_db) begin
                    state_d = WAIT_LOCK;
                    cause_d = CAUSE_BTN;
                end else if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cause_d = CAUSE_LOCK;
                end else if (wdt_expire) begin
                    state_d = WAIT_LOCK;
                    cause_d = CAUSE_WDT;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q  <= WAIT_LOCK;
            cause_q  <= CAUSE_POR;
            hold_cnt <= '0;
            O_rst_n  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            hold_cnt <= (state_q == HOLD) ? hold_cnt + 1'b1 : '0;
            O_rst_n  <= (state_d == RUN);
        end
    end

    assign O_in_reset  = ~O_rst_n;
    assign O_rst_cause = cause_q;

endmodule

// File: tb/tb_c5_reset_ctrl.sv
// Self-checking bench for c5_reset_ctrl: table-driven POR/glitch vectors plus hand-written
// sequences for button, lock loss, simultaneous events, watchdog and async reset.
`timescale 1ns/1ps
module tb_c5_reset_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int WDT  = 32;

    logic       I_clk;
    logic       I_rst_n;
    logic       I_rst_btn;
    logic       I_pll_locked;
    logic       I_wdt_kick;
    logic       O_rst_n;
    logic       O_in_reset;
    logic [1:0] O_rst_cause;

    int checks   = 0;
    int failures = 0;
    int edge_no  = 0;

    typedef struct {
        logic       exp_rst_n;
        logic [1:0] exp_cause;
        string      tag;
    } exp_t;

    typedef struct {
        logic       btn;
        logic       lock;
        logic       kick;
        logic       exp_rst_n;
        logic [1:0] exp_cause;
        string      tag;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[20];

    c5_reset_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .WDT_CYCLES     (WDT)
    ) dut (
        .I_clk       (I_clk),
        .I_rst_n     (I_rst_n),
        .I_rst_btn   (I_rst_btn),
        .I_pll_locked(I_pll_locked),
        .I_wdt_kick  (I_wdt_kick),
        .O_rst_n     (O_rst_n),
        .O_in_reset  (O_in_reset),
        .O_rst_cause (O_rst_cause)
    );

    initial begin
        I_clk = 1'b0;
        forever #5 I_clk = ~I_clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (edge %0d): got %0d expected %0d", tag, edge_no, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, queue the expectation, compare after the rising edge.
    task automatic cyc(input vec_t v);
        exp_t e;
        I_rst_btn    = v.btn;
        I_pll_locked = v.lock;
        I_wdt_kick   = v.kick;
        sb.push_back('{v.exp_rst_n, v.exp_cause, v.tag});
        @(posedge I_clk);
        edge_no++;
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty (edge %0d): got 0 expected 1 entries", edge_no);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_rst_n"},    {1'b0, O_rst_n},    {1'b0, e.exp_rst_n});
            check({e.tag, "_in_reset"}, {1'b0, O_in_reset}, {1'b0, ~e.exp_rst_n});
            check({e.tag, "_cause"},    O_rst_cause,        e.exp_cause);
        end
        @(negedge I_clk);
    endtask

    task automatic run(input int n, input logic btn, input logic lock, input logic kick,
                       input logic exp_rst_n, input logic [1:0] exp_cause, input string tag);
        for (int i = 0; i < n; i++) cyc('{btn, lock, kick, exp_rst_n, exp_cause, tag});
    endtask

    initial begin
        // POR release: edges 1..10 held in reset, release at edge 11; then a 3-cycle button glitch.
        for (int i = 0; i < 11; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, (i == 10), 2'd0, "por"};
        for (int i = 11; i < 14; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd0, "glitch"};
        for (int i = 14; i < 20; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, "glitch"};

        I_rst_n      = 1'b1;
        I_rst_btn    = 1'b0;
        I_pll_locked = 1'b1;
        I_wdt_kick   = 1'b0;
        #2 I_rst_n = 1'b0;
        repeat (3) @(negedge I_clk);
        check("reset_rst_n",     {1'b0, O_rst_n},    2'd0);
        check("reset_in_reset",  {1'b0, O_in_reset}, 2'd1);
        check("reset_cause",     O_rst_cause,        2'd0);
        I_rst_n = 1'b1;

        for (int i = 0; i < 20; i++) cyc(tbl[i]);

        // Button held 10 edges from e: falls at e+6, release completes at e+24.
        run(6,  1'b1, 1'b1, 1'b0, 1'b1, 2'd0, "btn_pre");
        run(4,  1'b1, 1'b1, 1'b0, 1'b0, 2'd1, "btn_fall");
        run(14, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, "btn_hold");
        run(1,  1'b0, 1'b1, 1'b0, 1'b1, 2'd1, "btn_rise");

        // Lock dropped from edge k for 5 edges: falls at k+2, relock at k+5 releases at k+15.
        run(2,  1'b0, 1'b0, 1'b0, 1'b1, 2'd1, "lock_pre");
        run(3,  1'b0, 1'b0, 1'b0, 1'b0, 2'd2, "lock_fall");
        run(10, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, "lock_hold");
        run(1,  1'b0, 1'b1, 1'b0, 1'b1, 2'd2, "lock_rise");

        // Button from e, lock lost from e+4: both seen by the FSM at e+6, button wins.
        run(4,  1'b1, 1'b1, 1'b0, 1'b1, 2'd2, "simul_pre");
        run(2,  1'b1, 1'b0, 1'b0, 1'b1, 2'd2, "simul_pre2");
        run(4,  1'b1, 1'b0, 1'b0, 1'b0, 2'd1, "simul_fall");
        run(14, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, "simul_hold");
        run(1,  1'b0, 1'b1, 1'b0, 1'b1, 2'd1, "simul_rise");

`ifdef RST_WDT_EN
        for (int i = 0; i < 10; i++) begin
            run(19, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, "wdt_kicked");
            run(1,  1'b0, 1'b1, 1'b1, 1'b1, 2'd1, "wdt_kick");
        end
        // Kick exactly on the expiry cycle must win.
        run(31, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, "wdt_edge");
        run(1,  1'b0, 1'b1, 1'b1, 1'b1, 2'd1, "wdt_late_kick");
        run(31, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, "wdt_starve");
        run(1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd3, "wdt_fall");
        run(8,  1'b0, 1'b1, 1'b1, 1'b0, 2'd3, "wdt_hold");
        run(1,  1'b0, 1'b1, 1'b1, 1'b1, 2'd3, "wdt_rise");
`else
        run(200, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, "no_wdt");
`endif

        // Async reset between edges, then power-up with the button held: HOLD aborts, cause stays 0.
        #2 I_rst_n = 1'b0;
        #1;
        check("async_rst_n",    {1'b0, O_rst_n},    2'd0);
        check("async_in_reset", {1'b0, O_in_reset}, 2'd1);
        check("async_cause",    O_rst_cause,        2'd0);
        I_rst_btn    = 1'b1;
        I_pll_locked = 1'b1;
        I_wdt_kick   = 1'b0;
        repeat (2) @(negedge I_clk);
        I_rst_n = 1'b1;
        run(9,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, "pwrup_btn");
        run(14, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, "pwrup_rel");
        run(1,  1'b0, 1'b1, 1'b0, 1'b1, 2'd0, "pwrup_rise");
        run(3,  1'b0, 1'b1, 1'b0, 1'b1, 2'd0, "pwrup_run");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
